// File: rtl/sd_cmd_lba_extract.sv
// sd_cmd_lba_extract: deserialises SD CMD tokens, checks framing/CRC7, turns CMD17/18/24/25 into {lba, op}
//   clk, rst_n                             clock, asynchronous active-low reset
//   sd_cmd_in, sd_cmd_en                   CMD line bit and its one-cycle strobe
//   hc_mode                                1 = block-addressed card, 0 = byte-addressed card
//   lba, lba_op, lba_valid, lba_ready      single-entry output register with valid/ready handshake
//   frame_err, addr_err, ovr_err, stop_seen  one-cycle status pulses
//   busy                                   a token is being shifted in or checked
module sd_cmd_lba_extract #(
  parameter int LBA_W = 32,
  parameter int BLK_SHIFT = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sd_cmd_in,
  input  logic             sd_cmd_en,
  input  logic             hc_mode,
  output logic [LBA_W-1:0] lba,
  output logic [1:0]       lba_op,
  output logic             lba_valid,
  input  logic             lba_ready,
  output logic             frame_err,
  output logic             addr_err,
  output logic             ovr_err,
  output logic             stop_seen,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
  state_t state, state_nx;
  logic [5:0] cnt;
  logic [6:0] crc, crc_nx;
  logic [46:0] sr;
  logic start, fb, chk, frame_ok, is_rw, aligned, take, hs, load;
  logic [5:0] idx;
  logic [31:0] arg, blk;
  logic [1:0] op;
  // sr holds token bits 2..48 once the 48th bit is in: sr[46]=tx, sr[0]=end
  always_comb begin
    start = sd_cmd_en & ~sd_cmd_in;
    fb = sd_cmd_in ^ crc[6];
    crc_nx = {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    idx = sr[45:40];
    arg = sr[39:8];
    blk = arg >> BLK_SHIFT;
    chk = state == CHECK;
    frame_ok = sr[46] & sr[0] & (crc == sr[7:1]);
    is_rw = idx == 6'd17 || idx == 6'd18 || idx == 6'd24 || idx == 6'd25;
    op = {idx[3], idx == 6'd18 || idx == 6'd25};
    aligned = (arg & ((32'd1 << BLK_SHIFT) - 32'd1)) == 32'd0;
    take = chk & frame_ok & is_rw & (hc_mode | aligned);
    hs = lba_valid & lba_ready;
    load = take & (~lba_valid | hs);
    busy = state != IDLE;
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? SHIFT : IDLE;
      SHIFT:   state_nx = (sd_cmd_en && cnt == 6'd47) ? CHECK : SHIFT;
      default: state_nx = start ? SHIFT : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      crc <= '0;
      sr <= '0;
      lba <= '0;
      lba_op <= '0;
      lba_valid <= 1'b0;
      frame_err <= 1'b0;
      addr_err <= 1'b0;
      ovr_err <= 1'b0;
      stop_seen <= 1'b0;
    end else begin
      state <= state_nx;
      frame_err <= chk & ~frame_ok;
      stop_seen <= chk & frame_ok & (idx == 6'd12);
      addr_err <= chk & frame_ok & is_rw & ~hc_mode & ~aligned;
      ovr_err <= take & ~load;
      if (load) begin
        lba <= hc_mode ? arg[LBA_W-1:0] : blk[LBA_W-1:0];
        lba_op <= op;
        lba_valid <= 1'b1;
      end else if (hs) lba_valid <= 1'b0;
      // CRC covers bits 1..40; the start bit is 0 so a cleared CRC already accounts for it
      if (state == SHIFT) begin
        if (sd_cmd_en) begin
          sr <= {sr[45:0], sd_cmd_in};
          cnt <= cnt + 6'd1;
          if (cnt < 6'd40) crc <= crc_nx;
        end
      end else if (start) begin
        cnt <= 6'd1;
        crc <= '0;
      end else if (chk) cnt <= '0;
    end
  end
endmodule

// File: tb/tb_sd_cmd_lba_extract.sv
// tb_sd_cmd_lba_extract: directed tokens against a token-level model of sd_cmd_lba_extract
module tb_sd_cmd_lba_extract;
  localparam int BS = 9;
  logic clk = 1'b0, rst_n = 1'b0;
  logic sd_cmd_in = 1'b1, sd_cmd_en = 1'b0, hc_mode = 1'b1, lba_ready = 1'b0;
  logic [31:0] lba;
  logic [1:0] lba_op;
  logic lba_valid, frame_err, addr_err, ovr_err, stop_seen, busy;
  int total = 0, passed = 0, cyc = 0;
  typedef struct packed {logic fe, ae, stop, take; logic [31:0] lba; logic [1:0] op;} res_t;
  typedef struct {logic [47:0] bits; int at;} tok_t;
  tok_t pend_q[$];
  res_t r;
  logic exp_valid, exp_fe, exp_ae, exp_ovr, exp_stop;
  logic [31:0] exp_lba;
  logic [1:0] exp_op;

  sd_cmd_lba_extract dut (
    .clk(clk), .rst_n(rst_n), .sd_cmd_in(sd_cmd_in), .sd_cmd_en(sd_cmd_en), .hc_mode(hc_mode),
    .lba(lba), .lba_op(lba_op), .lba_valid(lba_valid), .lba_ready(lba_ready),
    .frame_err(frame_err), .addr_err(addr_err), .ovr_err(ovr_err), .stop_seen(stop_seen), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] d;
    d = {m, 7'b0};
    for (int i = 46; i >= 7; i--) if (d[i]) d[i-:8] = d[i-:8] ^ 8'b1000_1001;
    return d[6:0];
  endfunction

  function automatic logic [47:0] make_tok(input int idx, input logic [31:0] arg, input logic flip, input logic end_bad);
    logic [39:0] m;
    m = {2'b01, 6'(idx), arg};
    return {m, crc7_ref(m) ^ {6'b0, flip}, ~end_bad};
  endfunction

  function automatic res_t judge(input logic [47:0] t, input logic hc);
    res_t x;
    int idx;
    x = '0;
    idx = int'(t[45:40]);
    case (idx)
      18: x.op = 2'd1;
      24: x.op = 2'd2;
      25: x.op = 2'd3;
      default: x.op = 2'd0;
    endcase
    if (!t[46] || !t[0] || t[7:1] != crc7_ref(t[47:8])) x.fe = 1'b1;
    else if (idx == 12) x.stop = 1'b1;
    else if (idx inside {17, 18, 24, 25}) begin
      if (hc) begin
        x.take = 1'b1;
        x.lba = t[39:8];
      end else if (t[39:8] % (2 ** BS) != 0) x.ae = 1'b1;
      else begin
        x.take = 1'b1;
        x.lba = t[39:8] / (2 ** BS);
      end
    end
    return x;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_valid <= 1'b0;
      exp_lba <= '0;
      exp_op <= '0;
      exp_fe <= 1'b0;
      exp_ae <= 1'b0;
      exp_ovr <= 1'b0;
      exp_stop <= 1'b0;
      pend_q.delete();
    end else begin
      cyc <= cyc + 1;
      exp_fe <= 1'b0;
      exp_ae <= 1'b0;
      exp_ovr <= 1'b0;
      exp_stop <= 1'b0;
      if (exp_valid && lba_ready) exp_valid <= 1'b0;
      if (pend_q.size() > 0 && pend_q[0].at == cyc + 1) begin
        r = judge(pend_q[0].bits, hc_mode);
        pend_q.pop_front();
        exp_fe <= r.fe;
        exp_ae <= r.ae;
        exp_stop <= r.stop;
        if (r.take) begin
          if (!exp_valid || lba_ready) begin
            exp_valid <= 1'b1;
            exp_lba <= r.lba;
            exp_op <= r.op;
          end else exp_ovr <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else passed++;
  endtask

  always @(negedge clk) begin
    chk("lba_valid", 64'(lba_valid), 64'(exp_valid));
    chk("frame_err", 64'(frame_err), 64'(exp_fe));
    chk("addr_err", 64'(addr_err), 64'(exp_ae));
    chk("ovr_err", 64'(ovr_err), 64'(exp_ovr));
    chk("stop_seen", 64'(stop_seen), 64'(exp_stop));
    if (exp_valid) begin
      chk("lba", 64'(lba), 64'(exp_lba));
      chk("lba_op", 64'(lba_op), 64'(exp_op));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_token(input logic [47:0] t);
    for (int i = 47; i >= 0; i--) begin
      sd_cmd_en = 1'b1;
      sd_cmd_in = t[i];
      if (i == 0) pend_q.push_back('{bits: t, at: cyc + 2});
      tick();
    end
    sd_cmd_en = 1'b0;
    sd_cmd_in = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sd_cmd_en = 1'b1;
      sd_cmd_in = 1'b1;
      tick();
    end
    sd_cmd_en = 1'b0;
  endtask

  task automatic drain();
    lba_ready = 1'b1;
    tick();
    lba_ready = 1'b0;
  endtask

  initial begin
    logic [47:0] t;
    repeat (3) @(posedge clk);
    #1;
    chk("rst lba", 64'(lba), 64'h0);
    chk("rst busy", 64'(busy), 64'h0);
    rst_n = 1'b1;
    chk("crc cmd0", 64'(crc7_ref({2'b01, 6'd0, 32'h0})), 64'h4A);
    chk("crc cmd8", 64'(crc7_ref({2'b01, 6'd8, 32'h1AA})), 64'h43);
    idle(3);
    send_token(make_tok(17, 32'h0000_1234, 1'b0, 1'b0));
    chk("cmd17 check valid", 64'(lba_valid), 64'h0);
    chk("cmd17 check busy", 64'(busy), 64'h1);
    tick();
    chk("cmd17 valid", 64'(lba_valid), 64'h1);
    chk("cmd17 lba", 64'(lba), 64'h1234);
    chk("cmd17 op", 64'(lba_op), 64'h0);
    chk("cmd17 busy", 64'(busy), 64'h0);
    idle(5);
    chk("cmd17 held", 64'(lba), 64'h1234);
    drain();
    chk("cmd17 drained", 64'(lba_valid), 64'h0);
    hc_mode = 1'b0;
    send_token(make_tok(25, 32'h0004_0000, 1'b0, 1'b0));
    tick();
    chk("cmd25 lba", 64'(lba), 64'h200);
    chk("cmd25 op", 64'(lba_op), 64'h3);
    drain();
    idle(2);
    send_token(make_tok(25, 32'h0004_0001, 1'b0, 1'b0));
    tick();
    chk("cmd25 addr_err", 64'(addr_err), 64'h1);
    chk("cmd25 no valid", 64'(lba_valid), 64'h0);
    hc_mode = 1'b1;
    send_token(make_tok(18, 32'h0000_0100, 1'b1, 1'b0));
    tick();
    chk("crc frame_err", 64'(frame_err), 64'h1);
    idle(1);
    send_token(make_tok(24, 32'h0000_0200, 1'b0, 1'b1));
    tick();
    chk("end frame_err", 64'(frame_err), 64'h1);
    chk("end no valid", 64'(lba_valid), 64'h0);
    idle(2);
    send_token(make_tok(0, 32'h0, 1'b0, 1'b0));
    tick();
    chk("cmd0 quiet", 64'({lba_valid, frame_err, addr_err, stop_seen}), 64'h0);
    send_token(make_tok(12, 32'h0, 1'b0, 1'b0));
    tick();
    chk("cmd12 stop", 64'(stop_seen), 64'h1);
    tick();
    chk("cmd12 pulse", 64'(stop_seen), 64'h0);
    send_token(make_tok(17, 32'h10, 1'b0, 1'b0));
    send_token(make_tok(17, 32'h20, 1'b0, 1'b0));
    tick();
    chk("b2b ovr", 64'(ovr_err), 64'h1);
    chk("b2b held", 64'(lba), 64'h10);
    drain();
    idle(2);
    send_token(make_tok(17, 32'h30, 1'b0, 1'b0));
    send_token(make_tok(17, 32'h40, 1'b0, 1'b0));
    lba_ready = 1'b1;
    tick();
    lba_ready = 1'b0;
    chk("b2b rdy lba", 64'(lba), 64'h40);
    chk("b2b rdy ovr", 64'(ovr_err), 64'h0);
    chk("b2b rdy valid", 64'(lba_valid), 64'h1);
    drain();
    send_token(make_tok(17, 32'h77, 1'b0, 1'b0));
    tick();
    chk("pre-rst held", 64'(lba), 64'h77);
    t = make_tok(24, 32'h0000_0500, 1'b0, 1'b0);
    for (int i = 47; i >= 18; i--) begin
      sd_cmd_en = 1'b1;
      sd_cmd_in = t[i];
      tick();
    end
    sd_cmd_en = 1'b0;
    chk("mid busy", 64'(busy), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("rst2 valid", 64'(lba_valid), 64'h0);
    chk("rst2 lba", 64'(lba), 64'h0);
    chk("rst2 op", 64'(lba_op), 64'h0);
    chk("rst2 busy", 64'(busy), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    send_token(make_tok(17, 32'h55, 1'b0, 1'b0));
    tick();
    chk("post-rst lba", 64'(lba), 64'h55);
    chk("post-rst valid", 64'(lba_valid), 64'h1);
    drain();
    idle(4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
